// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// Results are formed combinationally from latched operands; a countdown sets the visible latency.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MSUB  = 3'd7
    } op_e;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_e           op_q, op_d, op_in;

    logic [63:0] prod_s, prod_u;
    logic        div_sgn;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

    assign op_in = op_e'(op);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        div_sgn = (op_q == OP_DIV);
        a_mag   = (div_sgn && a_q[31]) ? -a_q : a_q;
        b_mag   = (div_sgn && b_q[31]) ? -b_q : b_q;
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq      = a_mag / b_safe;
        ur      = a_mag % b_safe;
        // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with no overflow case.
        quo     = (div_sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
        rem     = (div_sgn && a_q[31]) ? -ur : ur;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (start) begin
            case (op_in)
                OP_MULT, OP_MULTU, OP_MSUB: begin
                    op_d  = op_in;
                    a_d   = A;
                    b_d   = B;
                    cnt_d = CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    op_d  = op_in;
                    a_d   = A;
                    b_d   = B;
                    cnt_d = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_NONE;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule
